// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//
// Transmit side of the serial "11" detection path. Words are accepted through a
// valid/ready handshake and shifted out MSB-first, one bit per clock. A
// programmable run of forced-zero gap bits follows each word so the downstream
// detector settles back to its zero state. The block also counts emitted "11"
// pairs, including overlapping ones, for use as a scoreboard reference.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_data    word to transmit (WIDTH bits)
//   in_valid   in_data is valid
//   in_ready   block can accept a word this cycle (IDLE only)
//   out        serial data bit, 0 outside SHIFT
//   out_valid  out carries a data bit (SHIFT only)
//   busy       a word or its gap is in progress
//   done       one-cycle pulse in the first IDLE cycle after a word and its gap
//   pair_cnt   saturating count of emitted "11" pairs (PAIR_W bits)

module serial_pattern_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned PAIR_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [PAIR_W-1:0] pair_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  // gap_cnt holds at most GAP_CYCLES-1; keep at least one bit so GAP_CYCLES=0 still elaborates.
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              prev_q, prev_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              done_q, done_d;

  // Outputs decode straight from the state register so a reset drops the line at once.
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StShift);
  assign out       = out_valid & shift_q[WIDTH-1];
  assign done      = done_q;
  assign pair_cnt  = pair_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    // prev_bit only survives between bits of the same word; every other path clears it.
    prev_d    = 1'b0;
    pair_d    = pair_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d   = in_data;
          bit_cnt_d = LastBit;
          state_d   = StShift;
        end
      end

      StShift: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (out && prev_q && (pair_q != '1)) begin
          pair_d = pair_q + 1'b1;
        end
        if (bit_cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d   = StGap;
            gap_cnt_d = GapLoad;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          prev_d = out;
        end
      end

      StGap: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      prev_q    <= 1'b0;
      pair_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      prev_q    <= prev_d;
      pair_q    <= pair_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx. Two instances share clock and reset:
//   instance 0: WIDTH=8, GAP_CYCLES=2, PAIR_W=16
//   instance 1: WIDTH=8, GAP_CYCLES=0, PAIR_W=2
// A timeline model (cycles since acceptance) predicts every output each cycle.

module tb_serial_pattern_tx;

  localparam int unsigned W      = 8;
  localparam int unsigned GAP_A  = 2;
  localparam int unsigned GAP_B  = 0;
  localparam int unsigned PMAX_A = 65535;
  localparam int unsigned PMAX_B = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data [2];
  logic         in_valid [2];
  logic [1:0]   o_out, o_valid, o_ready, o_busy, o_done;
  logic [15:0]  pair_a;
  logic [1:0]   pair_b;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP_A), .PAIR_W(16)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (o_ready[0]),
    .out       (o_out[0]),
    .out_valid (o_valid[0]),
    .busy      (o_busy[0]),
    .done      (o_done[0]),
    .pair_cnt  (pair_a)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP_B), .PAIR_W(2)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (o_ready[1]),
    .out       (o_out[1]),
    .out_valid (o_valid[1]),
    .busy      (o_busy[1]),
    .done      (o_done[1]),
    .pair_cnt  (pair_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: a word occupies cycles t=1..W (data), W+1..W+gap (zeros); done follows.
  bit           m_active [2];
  int unsigned  m_t      [2];
  logic [W-1:0] m_word   [2];
  int unsigned  m_pairs  [2];
  bit           m_done   [2];
  int unsigned  acc_count [2];
  int unsigned  acc_cycle [2];
  int unsigned  done_cycle [2];
  int unsigned  done_seen  [2];
  logic [W-1:0] stream [2];
  int unsigned  cycle = 0;

  logic         e_out, e_valid, e_ready, e_busy, e_done;
  int unsigned  gi, pmax, act_pair;

  always @(negedge clk) begin
    cycle++;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_active[i] = 1'b0;
        m_t[i]      = 0;
        m_pairs[i]  = 0;
        m_done[i]   = 1'b0;
      end
      gi   = (i == 0) ? GAP_A : GAP_B;
      pmax = (i == 0) ? PMAX_A : PMAX_B;

      if (m_active[i]) begin
        e_busy  = 1'b1;
        e_ready = 1'b0;
        e_done  = 1'b0;
        if (m_t[i] <= W) begin
          e_valid = 1'b1;
          e_out   = m_word[i][W - m_t[i]];
        end else begin
          e_valid = 1'b0;
          e_out   = 1'b0;
        end
      end else begin
        e_busy  = 1'b0;
        e_ready = 1'b1;
        e_valid = 1'b0;
        e_out   = 1'b0;
        e_done  = m_done[i];
      end

      act_pair = (i == 0) ? 32'(pair_a) : 32'(pair_b);
      check($sformatf("out[%0d]", i), 32'(o_out[i]), 32'(e_out));
      check($sformatf("out_valid[%0d]", i), 32'(o_valid[i]), 32'(e_valid));
      check($sformatf("in_ready[%0d]", i), 32'(o_ready[i]), 32'(e_ready));
      check($sformatf("busy[%0d]", i), 32'(o_busy[i]), 32'(e_busy));
      check($sformatf("done[%0d]", i), 32'(o_done[i]), 32'(e_done));
      check($sformatf("pair_cnt[%0d]", i), act_pair, m_pairs[i]);

      if (o_valid[i] === 1'b1) stream[i] = {stream[i][W-2:0], o_out[i]};
      if (o_done[i] === 1'b1) begin
        done_cycle[i] = cycle;
        done_seen[i]++;
      end

      // Advance the model across the coming rising edge.
      if (reset_n) begin
        if (!m_active[i]) begin
          m_done[i] = 1'b0;
          if (in_valid[i]) begin
            m_active[i] = 1'b1;
            m_t[i]      = 1;
            m_word[i]   = in_data[i];
            acc_count[i]++;
            acc_cycle[i] = cycle;
          end
        end else begin
          if (m_t[i] >= 2 && m_t[i] <= W) begin
            if (m_word[i][W - m_t[i]] && m_word[i][W - m_t[i] + 1] && m_pairs[i] < pmax)
              m_pairs[i]++;
          end
          if (m_t[i] == W + gi) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b1;
          end else begin
            m_t[i]++;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int i, input logic [W-1:0] d);
    int unsigned c0;
    c0 = acc_count[i];
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    for (int k = 0; k < 40 && acc_count[i] == c0; k++) @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    check($sformatf("accept[%0d]", i), acc_count[i], c0 + 1);
  endtask

  int unsigned c0, a1, ds0;

  initial begin
    reset_n     = 1'b0;
    in_valid    = '{1'b0, 1'b0};
    in_data     = '{'0, '0};
    acc_count   = '{0, 0};
    acc_cycle   = '{0, 0};
    done_cycle  = '{0, 0};
    done_seen   = '{0, 0};
    stream      = '{'0, '0};
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_ready", 32'(o_ready[0]), 1);
    check("idle_pair", 32'(pair_a), 0);

    // 8'hB7: stream 1,0,1,1,0,1,1,1 and three pairs; done 11 clocks after accept.
    stream[0] = '0;
    send(0, 8'hB7);
    repeat (12) @(posedge clk);
    #1;
    check("b7_stream", 32'(stream[0]), 32'h0000_00B7);
    check("b7_pairs", 32'(pair_a), 3);
    check("b7_done_lat", done_cycle[0] - acc_cycle[0], 11);

    // 8'hFF then 8'h00 with in_valid held: second accept 11 clocks later.
    c0 = acc_count[0];
    in_data[0]  = 8'hFF;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 40 && acc_count[0] == c0; k++) @(posedge clk);
    #1;
    a1 = acc_cycle[0];
    in_data[0] = 8'h00;
    for (int k = 0; k < 40 && acc_count[0] == c0 + 1; k++) @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("b2b_accepts", acc_count[0], c0 + 2);
    check("b2b_spacing", acc_cycle[0] - a1, 11);
    check("ff_pairs", 32'(pair_a), 10);
    repeat (12) @(posedge clk);
    #1;
    check("00_pairs", 32'(pair_a), 10);

    // 8'h0F with an ignored 8'hAA pulse mid-shift.
    stream[0] = '0;
    c0 = acc_count[0];
    send(0, 8'h0F);
    repeat (3) @(posedge clk);
    #1;
    in_data[0]  = 8'hAA;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("0f_stream", 32'(stream[0]), 32'h0000_000F);
    check("0f_pairs", 32'(pair_a), 13);
    check("aa_ignored", acc_count[0], c0 + 1);

    // Reset during the 4th bit of 8'hF0.
    send(0, 8'hF0);
    repeat (3) @(posedge clk);
    #1;
    ds0 = done_seen[0];
    reset_n = 1'b0;
    #1;
    check("rst_out", 32'(o_out[0]), 0);
    check("rst_pairs", 32'(pair_a), 0);
    check("rst_busy", 32'(o_busy[0]), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_done", done_seen[0], ds0);

    stream[0] = '0;
    send(0, 8'hC3);
    repeat (12) @(posedge clk);
    #1;
    check("c3_stream", 32'(stream[0]), 32'h0000_00C3);
    check("c3_pairs", 32'(pair_a), 2);

    // Instance 1: saturating 2-bit counter and zero-gap done timing.
    stream[1] = '0;
    send(1, 8'hFF);
    repeat (10) @(posedge clk);
    #1;
    check("sat_stream", 32'(stream[1]), 32'h0000_00FF);
    check("sat_pairs", 32'(pair_b), 3);
    check("nogap_done_lat", done_cycle[1] - acc_cycle[1], 9);

    // Randomized traffic on both instances, including in_valid while busy.
    fork
      for (int n = 0; n < 500; n++) begin
        @(posedge clk);
        #1;
        in_valid[0] = ($urandom_range(0, 3) == 0);
        in_data[0]  = W'($urandom);
      end
      for (int n = 0; n < 500; n++) begin
        @(posedge clk);
        #1;
        in_valid[1] = ($urandom_range(0, 2) == 0);
        in_data[1]  = W'($urandom);
      end
    join
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
